// File: rtl/svsd_pkg.sv
// Shared codes, glyphs and decode helper for the svsd display receiver.
// Segment constants are active-high, bit order {g,f,e,d,c,b,a}.
package svsd_pkg;

   localparam logic [3:0] SVSD_CODE_DASH  = 4'hA;
   localparam logic [3:0] SVSD_CODE_BLANK = 4'hF;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   // Codes B..F all fall through to blank.
   function automatic logic [6:0] svsd_decode(
      input logic [3:0] code
   );
      logic [6:0] seg;
      seg = SEG_OFF;
      case (code)
         4'd0:           seg = SEG_0;
         4'd1:           seg = SEG_1;
         4'd2:           seg = SEG_2;
         4'd3:           seg = SEG_3;
         4'd4:           seg = SEG_4;
         4'd5:           seg = SEG_5;
         4'd6:           seg = SEG_6;
         4'd7:           seg = SEG_7;
         4'd8:           seg = SEG_8;
         4'd9:           seg = SEG_9;
         SVSD_CODE_DASH: seg = SEG_DASH;
         default:        seg = SEG_OFF;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/svsd_seg_decode.sv
// One digit of 4-bit code to active-high seven-segment pattern.
// Purely combinational; the top registers the result.
module svsd_seg_decode
   import svsd_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   // Table lookup through the shared package helper.
   always_comb begin
      seg = svsd_decode(code);
   end

endmodule

// File: rtl/svsd_display_rx.sv
// Receives six svsd digit exports, filters torn updates, decodes and blinks.
// Optional SVSD_LZB_EN macro enables leading-zero blanking.
module svsd_display_rx
   import svsd_pkg::*;
#(
   parameter int NUM_DIGITS        = 6,
   parameter int STABLE_CYCLES     = 1024,
   parameter int BLINK_HALF_PERIOD = 25000000,
   parameter int SEG_ACTIVE_LOW    = 1
) (
   input  logic                    clk_clk,
   input  logic                    reset_reset,
   input  logic [4*NUM_DIGITS-1:0] svsd_digits_i,
   input  logic [NUM_DIGITS-1:0]   blink_mask_i,
   output logic [7*NUM_DIGITS-1:0] hex_o,
   output logic                    update_pulse_o,
   output logic                    stable_o
);

   localparam int SCW = $clog2(STABLE_CYCLES + 1);
   localparam int BCW = (BLINK_HALF_PERIOD > 1) ?
                        $clog2(BLINK_HALF_PERIOD) : 1;

   localparam logic [SCW-1:0] SC_MAX = SCW'(STABLE_CYCLES);
   localparam logic [BCW-1:0] BC_MAX = BCW'(BLINK_HALF_PERIOD - 1);

   localparam logic [7*NUM_DIGITS-1:0] HEX_OFF =
      (SEG_ACTIVE_LOW != 0) ? {7*NUM_DIGITS{1'b1}} :
                              {7*NUM_DIGITS{1'b0}};

   logic [4*NUM_DIGITS-1:0] samp;
   logic [4*NUM_DIGITS-1:0] committed;
   logic [SCW-1:0]          scnt;
   logic                    commit_en;

   logic [BCW-1:0]          bcnt;
   logic                    phase;
   logic [NUM_DIGITS-1:0]   mask_q;
   logic                    restart;
   logic                    phase_eff;

   logic [6:0]              seg_dec [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   lzb_blank;
   logic [7*NUM_DIGITS-1:0] seg_raw;

   assign commit_en = (scnt == SC_MAX) && (samp != committed);

   assign restart   = (mask_q == '0) && (blink_mask_i != '0);

   // A fresh blink start must show digits, even before phase clears.
   assign phase_eff = phase & ~restart;

   // Sample the exports and count how long they have stayed unchanged.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         samp     <= '0;
         scnt     <= '0;
         stable_o <= 1'b0;
      end else begin
         samp     <= svsd_digits_i;
         stable_o <= (scnt == SC_MAX);
         if (svsd_digits_i != samp)
            scnt <= '0;
         else if (scnt != SC_MAX)
            scnt <= scnt + SCW'(1);
      end
   end

   // Commit a stable, changed digit set and flag it for one cycle.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         committed      <= {NUM_DIGITS{SVSD_CODE_BLANK}};
         update_pulse_o <= 1'b0;
      end else begin
         update_pulse_o <= commit_en;
         if (commit_en)
            committed <= samp;
      end
   end

   // Free-running blink phase, restarted when blinking is first enabled.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         bcnt   <= '0;
         phase  <= 1'b0;
         mask_q <= '0;
      end else begin
         mask_q <= blink_mask_i;
         if (restart) begin
            bcnt  <= '0;
            phase <= 1'b0;
         end else if (bcnt == BC_MAX) begin
            bcnt  <= '0;
            phase <= ~phase;
         end else begin
            bcnt <= bcnt + BCW'(1);
         end
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
      svsd_seg_decode u_dec (
         .code (committed[4*g +: 4]),
         .seg  (seg_dec[g])
      );
   end

   // Leading zeros from the top digit down; digit 0 always shows.
   always_comb begin
      lzb_blank = '0;
`ifdef SVSD_LZB_EN
      begin : lzb_scan
         logic lead;
         lead = 1'b1;
         for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (lead && (committed[4*i +: 4] == 4'd0))
               lzb_blank[i] = 1'b1;
            else
               lead = 1'b0;
         end
      end
`endif
   end

   // Apply zero blanking and blink blanking to each decoded group.
   always_comb begin
      seg_raw = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (lzb_blank[i] || (phase_eff && blink_mask_i[i]))
            seg_raw[7*i +: 7] = SEG_OFF;
         else
            seg_raw[7*i +: 7] = seg_dec[i];
      end
   end

   // Register the segment drive in the board polarity.
   always_ff @(posedge clk_clk) begin
      if (reset_reset)
         hex_o <= HEX_OFF;
      else if (SEG_ACTIVE_LOW != 0)
         hex_o <= ~seg_raw;
      else
         hex_o <= seg_raw;
   end

endmodule

// File: tb/tb_svsd_display_rx.sv
// Directed bench for svsd_display_rx with short stability and blink periods.
// Table vectors cover decode; hand sequences cover timing and blinking.
module tb_svsd_display_rx;

   typedef struct {
      logic [23:0] d;
      logic [41:0] h;
      int          np;
   } vec_t;

   localparam logic [41:0] HEX_OFF = {6{7'h7F}};
   localparam logic [41:0] HEX_A =
      {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
   localparam logic [41:0] HEX_A_B01 =
      {7'h79, 7'h24, 7'h30, 7'h19, 7'h7F, 7'h7F};
   localparam logic [41:0] HEX_A_B0 =
      {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h7F};

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] digits;
   logic [5:0]  mask;
   logic [41:0] hex;
   logic        pulse;
   logic        stable;

   int total = 0;
   int bad   = 0;
   int npulse = 0;

   vec_t tv [7];

   always #5 clk = ~clk;

   svsd_display_rx #(
      .NUM_DIGITS        (6),
      .STABLE_CYCLES     (4),
      .BLINK_HALF_PERIOD (8),
      .SEG_ACTIVE_LOW    (1)
   ) dut (
      .clk_clk        (clk),
      .reset_reset    (rst),
      .svsd_digits_i  (digits),
      .blink_mask_i   (mask),
      .hex_o          (hex),
      .update_pulse_o (pulse),
      .stable_o       (stable)
   );

   always @(posedge clk) begin
      if (pulse === 1'b1)
         npulse++;
   end

   task automatic chk(
      input string       nm,
      input logic [41:0] act,
      input logic [41:0] exp
   );
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   initial begin
      int p0;
      int viol;
      logic [41:0] exp;

      tv[0] = '{24'h123456, HEX_A, 0};
      tv[1] = '{24'hAF0000,
                {7'h3F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40}, 1};
`ifdef SVSD_LZB_EN
      tv[2] = '{24'h000123,
                {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30}, 1};
      tv[4] = '{24'h000000,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 1};
      tv[5] = '{24'h050EDA,
                {7'h7F, 7'h12, 7'h40, 7'h7F, 7'h7F, 7'h3F}, 1};
`else
      tv[2] = '{24'h000123,
                {7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30}, 1};
      tv[4] = '{24'h000000,
                {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 1};
      tv[5] = '{24'h050EDA,
                {7'h40, 7'h12, 7'h40, 7'h7F, 7'h7F, 7'h3F}, 1};
`endif
      tv[3] = '{24'h789ABC,
                {7'h78, 7'h00, 7'h10, 7'h3F, 7'h7F, 7'h7F}, 1};
      tv[6] = '{24'h123456, HEX_A, 1};

      rst    = 1'b1;
      digits = 24'h123456;
      mask   = '0;
      repeat (3) @(negedge clk);
      chk("reset hex", hex, HEX_OFF);
      chk("reset pulse", 42'(pulse), 42'd0);
      chk("reset stable", 42'(stable), 42'd0);

      rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 5) begin
            chk("pre pulse", 42'(pulse), 42'd0);
            chk("pre stable", 42'(stable), 42'd0);
         end
         if (k == 6) begin
            chk("commit pulse", 42'(pulse), 42'd1);
            chk("sat stable", 42'(stable), 42'd1);
         end
         if (k == 7) begin
            chk("pulse width", 42'(pulse), 42'd0);
            chk("first hex", hex, HEX_A);
         end
      end
      repeat (20) @(negedge clk);
      chk("single pulse", 42'(npulse), 42'd1);

      for (int i = 0; i < 7; i++) begin
         digits = tv[i].d;
         p0 = npulse;
         repeat (8) @(negedge clk);
         chk($sformatf("vec%0d hex", i), hex, tv[i].h);
         chk($sformatf("vec%0d pulses", i),
             42'(npulse - p0), 42'(tv[i].np));
      end

      p0 = npulse;
      viol = 0;
      for (int c = 0; c < 40; c++) begin
         digits = (((c / 2) % 2) == 1) ? 24'h999999 : 24'h123456;
         @(negedge clk);
         if (hex !== HEX_A)
            viol++;
         if (c >= 3 && stable !== 1'b0)
            viol++;
      end
      chk("toggle viol", 42'(viol), 42'd0);
      chk("toggle pulses", 42'(npulse - p0), 42'd0);
      digits = 24'h123456;
      repeat (10) @(negedge clk);
      chk("resettle pulses", 42'(npulse - p0), 42'd0);
      chk("resettle stable", 42'(stable), 42'd1);

      mask = 6'b000011;
      for (int k = 1; k <= 27; k++) begin
         @(negedge clk);
         exp = ((k >= 10 && k <= 17) || k >= 26) ? HEX_A_B01 : HEX_A;
         if (k >= 2)
            chk($sformatf("blink k%0d", k), hex, exp);
      end
      mask = 6'b000001;
      @(negedge clk);
      chk("mask change", hex, HEX_A_B0);

      rst = 1'b1;
      @(negedge clk);
      chk("midblink rst hex", hex, HEX_OFF);
      chk("midblink rst stable", 42'(stable), 42'd0);
      chk("midblink rst pulse", 42'(pulse), 42'd0);

      rst  = 1'b0;
      mask = '0;
      p0 = npulse;
      repeat (8) @(negedge clk);
      chk("post rst hex", hex, HEX_A);
      chk("post rst pulses", 42'(npulse - p0), 42'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
